// File: rtl/reg_pkg.sv
// Shared types for the register file and the ALU: register names and the NZCV status word.
package reg_pkg;

    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;

    typedef enum logic [SEL_W-1:0] {
        R0  = 4'd0,
        R1  = 4'd1,
        R2  = 4'd2,
        R3  = 4'd3,
        R4  = 4'd4,
        R5  = 4'd5,
        R6  = 4'd6,
        R7  = 4'd7,
        R8  = 4'd8,
        R9  = 4'd9,
        R10 = 4'd10,
        R11 = 4'd11,
        R12 = 4'd12,
        R13 = 4'd13,
        SP  = 4'd14,
        PC  = 4'd15
    } reg_e;

    // Packed NZCV; carry sits at bit 1 so the ALU can pick it out directly.
    typedef struct packed {
        logic n;
        logic z;
        logic carry;
        logic v;
    } status_t;

endpackage

// File: rtl/status_reg.sv
// NZCV flag register: async active-low clear, load enable, registered output.
module status_reg
    import reg_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    ld,
    input  status_t d,
    output status_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 16 x WIDTH register file with r15 as PC, two tri-state read buses and an NZCV status register.
// The status register is built only when REG_FILE_STATUS_EN is defined; otherwise status reads as 0.
module reg_file
    import reg_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_e             sel_a,
    input  logic             oe_a,
    input  reg_e             sel_b,
    input  logic             oe_b,
    output tri logic [WIDTH-1:0] a,
    output tri logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  reg_e             sel_in,
    input  logic             ld,
    input  logic             pc_inc,
    input  status_t          alu_status,
    input  logic             status_ld,
    output status_t          status,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             pc_loaded;

    // An explicit load of r15 takes priority over the increment.
    assign pc_loaded = ld && (sel_in == PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '{default: '0};
            regs[PC] <= PC_RESET;
        end else begin
            if (ld) begin
                regs[sel_in] <= result;
            end
            if (pc_inc && !pc_loaded) begin
                regs[PC] <= regs[PC] + ONE;
            end
        end
    end

    // No write bypass: reads always see the pre-edge value, breaking any loop through the ALU.
    assign a = oe_a ? regs[sel_a] : {WIDTH{1'bz}};
    assign b = oe_b ? regs[sel_b] : {WIDTH{1'bz}};

`ifdef REG_FILE_STATUS_EN
    status_reg u_status_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (status_ld),
        .d     (alu_status),
        .q     (status)
    );
`else
    logic unused_status_in;
    assign unused_status_in = ^{status_ld, alu_status};
    assign status           = '0;
`endif

    assign carry_out = status.carry;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps then randomized traffic against an array model.
module tb_reg_file;
    import reg_pkg::*;

    localparam int               W        = 32;
    localparam logic [W-1:0]     PC_RST   = 32'h0000_0000;
    localparam logic [W-1:0]     PULLED   = '1;
`ifdef REG_FILE_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_e         sel_a, sel_b, sel_in;
    logic         oe_a, oe_b, ld, pc_inc, status_ld;
    logic [W-1:0] result;
    status_t      alu_status;
    status_t      status;
    logic         carry_out;
    // Weak pull-ups make an undriven bus observable as all ones.
    tri1 [W-1:0]  a;
    tri1 [W-1:0]  b;

    reg_file #(.WIDTH(W), .PC_RESET(PC_RST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_a      (sel_a),
        .oe_a       (oe_a),
        .sel_b      (sel_b),
        .oe_b       (oe_b),
        .a          (a),
        .b          (b),
        .result     (result),
        .sel_in     (sel_in),
        .ld         (ld),
        .pc_inc     (pc_inc),
        .alu_status (alu_status),
        .status_ld  (status_ld),
        .status     (status),
        .carry_out  (carry_out)
    );

    // reference model and scoreboard
    logic [W-1:0] m_regs [16];
    logic [3:0]   m_status;
    logic [W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_regs[15] = PC_RST;
        m_status   = 4'h0;
    endtask

    // Architectural effect of one clock edge with the inputs currently applied.
    task automatic model_edge();
        logic [W-1:0] next_pc;
        next_pc = m_regs[15];
        if (pc_inc) next_pc = m_regs[15] + 32'd1;
        if (ld) m_regs[int'(sel_in)] = result;
        if (!(ld && int'(sel_in) == 15)) m_regs[15] = next_pc;
        if (status_ld && STATUS_EN) m_status = alu_status;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sel_a = R0; sel_b = R0; sel_in = R0;
        oe_a = 1'b0; oe_b = 1'b0; ld = 1'b0; pc_inc = 1'b0; status_ld = 1'b0;
        result = '0; alu_status = '0;
    endtask

    function automatic logic [W-1:0] bus_exp(input logic oe, input reg_e sel);
        return oe ? m_regs[int'(sel)] : PULLED;
    endfunction

    initial begin
        // reset then read
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("status_in_reset", {28'b0, status}, 32'h0);
        check("carry_in_reset", {31'b0, carry_out}, 32'h0);
        rst_n = 1'b1;
        oe_a = 1'b1; sel_a = R3;
        #1 check("reset_r3", a, 32'h0);
        sel_a = PC;
        #1 check("reset_pc", a, PC_RST);
        oe_a = 1'b0;
        #1 check("a_high_z", a, PULLED);
        check("b_high_z", b, PULLED);

        // write then read, no bypass
        @(posedge clk); #1;
        ld = 1'b1; sel_in = R5; result = 32'hDEAD_BEEF;
        oe_a = 1'b1; sel_a = R5;
        #1 check("r5_no_bypass", a, 32'h0);
        tick();
        ld = 1'b0; oe_b = 1'b1; sel_b = R5;
        #1 check("r5_a_after", a, 32'hDEAD_BEEF);
        check("r5_b_after", b, 32'hDEAD_BEEF);

        // PC wrap and load-over-increment priority
        oe_b = 1'b0;
        ld = 1'b1; sel_in = PC; result = 32'hFFFF_FFFF;
        tick();
        ld = 1'b0; pc_inc = 1'b1; sel_a = PC;
        #1 check("pc_loaded_max", a, 32'hFFFF_FFFF);
        tick();
        check("pc_wrap", a, 32'h0);
        ld = 1'b1; sel_in = PC; result = 32'h0000_0100; pc_inc = 1'b1;
        tick();
        check("pc_ld_beats_inc", a, 32'h0000_0100);
        ld = 1'b0;
        tick();
        check("pc_inc_plain", a, 32'h0000_0101);
        pc_inc = 1'b0;

        // carry round-trip
        alu_status = 4'b0010; status_ld = 1'b1;
        tick();
        status_ld = 1'b0; alu_status = 4'b0000;
        #1 check("carry_latched", {31'b0, carry_out}, {31'b0, STATUS_EN});
        tick();
        check("carry_held", {31'b0, carry_out}, {31'b0, STATUS_EN});
        check("status_held", {28'b0, status}, {28'b0, m_status});
        alu_status = 4'b1111; status_ld = 1'b1;
        tick();
        status_ld = 1'b0;
        check("status_all_ones", {28'b0, status}, STATUS_EN ? 32'hF : 32'h0);
        check("carry_all_ones", {31'b0, carry_out}, {31'b0, STATUS_EN});

        // back-to-back loads into the same register
        sel_a = R9; ld = 1'b1; sel_in = R9;
        for (int i = 0; i < 3; i++) begin
            result = $urandom;
            tick();
            check("b2b_r9", a, m_regs[9]);
        end
        ld = 1'b0;

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel_a      = reg_e'($urandom_range(0, 15));
            sel_b      = reg_e'($urandom_range(0, 15));
            sel_in     = reg_e'($urandom_range(0, 15));
            oe_a       = ($urandom_range(0, 3) != 0);
            oe_b       = ($urandom_range(0, 3) != 0);
            ld         = $urandom_range(0, 1);
            pc_inc     = $urandom_range(0, 1);
            status_ld  = $urandom_range(0, 1);
            alu_status = 4'($urandom_range(0, 15));
            result     = $urandom;
            if ($urandom_range(0, 15) == 0) result = 32'hFFFF_FFFF;
            exp_q.push_back(bus_exp(oe_a, sel_a));
            exp_q.push_back(bus_exp(oe_b, sel_b));
            #1;
            check("rnd_a", a, exp_q.pop_front());
            check("rnd_b", b, exp_q.pop_front());
            check("rnd_status_pre", {28'b0, status}, {28'b0, m_status});
            tick();
            check("rnd_status", {28'b0, status}, {28'b0, m_status});
            check("rnd_carry", {31'b0, carry_out}, {31'b0, m_status[1]});
        end

        // async reset in the middle of a cycle with a write pending
        idle_inputs();
        ld = 1'b1; sel_in = R7; result = 32'h0000_CAFE;
        alu_status = 4'b0010; status_ld = 1'b1;
        tick();
        oe_a = 1'b1; sel_a = R7;
        result = 32'h0000_1234; alu_status = 4'b1111;
        #1 check("r7_before_reset", a, 32'h0000_CAFE);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("r7_async_clear", a, 32'h0);
        check("status_async_clear", {28'b0, status}, 32'h0);
        check("carry_async_clear", {31'b0, carry_out}, 32'h0);
        oe_b = 1'b1; sel_b = PC;
        #1 check("pc_async_reset", b, PC_RST);
        @(posedge clk); #1;
        ld = 1'b0; status_ld = 1'b0;
        rst_n = 1'b1;
        tick();
        check("r7_after_release", a, 32'h0);
        check("status_after_release", {28'b0, status}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
